mem_port_arbiter: RTL and testbench

Shares the single byte-wide, one-cycle-latency instruction/data memory port between the instruction fetch unit (port 0) and the load/store unit (port 1). Each requester asks for a 1–4 byte burst, read or write, at a byte address. The arbiter grants one burst at a time with round-robin priority and sequences the byte addresses. For reads it assembles the returned bytes into a big-endian, left-justified 32-bit word. It sits between the core front-end/LSU and the memory model/BRAM.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, constants and byte helpers for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int PORT_FETCH = 0;
    localparam int PORT_LSU   = 1;
    localparam int MAX_BURST  = 4;
    localparam int DATA_WIDTH = 8;

    // Byte k of a big-endian word: byte 0 lives in [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        logic [31:0] s;
        s = w << {k, 3'b000};
        return s[31:24];
    endfunction

    // Replace byte slot k of a big-endian word with b, leaving other slots intact.
    function automatic logic [31:0] place_byte(input logic [31:0] w, input logic [1:0] k,
                                               input logic [7:0] b);
        logic [31:0] mask;
        logic [31:0] val;
        mask = 32'hFF00_0000 >> {k, 3'b000};
        val  = {b, 24'h00_0000} >> {k, 3'b000};
        return (w & ~mask) | val;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin pick with last-grant memory
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       pick_port
);

    logic last;

    // On contention the port that did not win last time goes first.
    always_comb begin
        pick_port = req[1];
        if (req == 2'b11) begin
            pick_port = ~last;
        end
    end

    // Remember the winner only when the burst is actually accepted; fetch wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= pick_port;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares a byte-wide memory port between fetch and load/store bursts
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [1:0]              i_req,
    input  logic [1:0]              i_we,
    input  logic [2*ADDR_WIDTH-1:0] i_addr,
    input  logic [3:0]              i_len,
    input  logic [63:0]             i_wdata,
    output logic [1:0]              o_gnt,
    output logic [1:0]              o_done,
    output logic [31:0]             o_rdata,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]   i_mem_data
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic                  accept;
    logic                  win;
    logic                  port_q;
    logic                  we_q;
    logic [1:0]            len_q;
    logic [1:0]            idx_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [1:0]            done_q;
    logic [1:0]            port_onehot;

    rr_arbiter2 u_rr (
        .clk       (i_clk),
        .rst       (i_rst),
        .req       (i_req),
        .accept    (accept),
        .pick_port (win)
    );

    assign port_onehot = port_q ? 2'b10 : 2'b01;
    assign o_done      = done_q;
    assign o_rdata     = rdata_q;
    assign o_mem_addr  = mem_addr_q;

    // Next-state and memory-side strobes; the last issued byte decides write-done versus read-drain.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        o_gnt       = 2'b00;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                o_gnt = port_onehot;
                if (we_q) begin
                    o_mem_we    = 1'b1;
                    o_mem_wdata = word_byte(wdata_q, idx_q);
                end
                if (idx_q == len_q) begin
                    state_d = we_q ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                o_gnt   = port_onehot;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any burst without a completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst latch, byte counter, address sequencing and read assembly (memory data lags its address by one edge).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            len_q      <= 2'd0;
            idx_q      <= 2'd0;
            base_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            mem_addr_q <= '0;
            done_q     <= 2'b00;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        port_q     <= win;
                        we_q       <= win ? i_we[1] : i_we[0];
                        len_q      <= win ? i_len[3:2] : i_len[1:0];
                        base_q     <= win ? i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_addr[ADDR_WIDTH-1:0];
                        mem_addr_q <= win ? i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_addr[ADDR_WIDTH-1:0];
                        wdata_q    <= win ? i_wdata[63:32] : i_wdata[31:0];
                        rdata_q    <= 32'h0;
                        idx_q      <= 2'd0;
                    end
                end
                ISSUE: begin
                    if (!we_q && idx_q != 2'd0) begin
                        rdata_q <= place_byte(rdata_q, idx_q - 2'd1, i_mem_data);
                    end
                    if (idx_q == len_q) begin
                        if (we_q) begin
                            done_q <= port_onehot;
                        end
                    end else begin
                        idx_q      <= idx_q + 2'd1;
                        mem_addr_q <= base_q + ADDR_WIDTH'(idx_q + 2'd1);
                    end
                end
                DRAIN: begin
                    rdata_q <= place_byte(rdata_q, len_q, i_mem_data);
                    done_q  <= port_onehot;
                end
                default: begin
                    done_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for the memory port arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  i_req;
    logic [1:0]  i_we;
    logic [63:0] i_addr;
    logic [3:0]  i_len;
    logic [63:0] i_wdata;
    logic [1:0]  o_gnt;
    logic [1:0]  o_done;
    logic [31:0] o_rdata;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  mem_rd;

    int checks;
    int errors;

    logic [7:0]  mem [256];
    logic [7:0]  shadow [256];
    logic        load_mem;
    int          tb_last;

    bit          b_we    [2];
    logic [31:0] b_addr  [2];
    logic [1:0]  b_len   [2];
    logic [31:0] b_wdata [2];

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_len       (i_len),
        .i_wdata     (i_wdata),
        .o_gnt       (o_gnt),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_data  (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0:       return 8'hAA;
            1:       return 8'hBB;
            2:       return 8'hCC;
            3:       return 8'hDD;
            255:     return 8'h5A;
            default: return 8'h00;
        endcase
    endfunction

    // Registered byte-wide memory: data appears the cycle after its address.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else begin
            mem_rd <= mem[o_mem_addr[7:0]];
            if (o_mem_we) mem[o_mem_addr[7:0]] <= o_mem_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic set_port(input int p, input bit we, input logic [31:0] a,
                            input logic [1:0] len, input logic [31:0] wd);
        b_we[p]    = we;
        b_addr[p]  = a;
        b_len[p]   = len;
        b_wdata[p] = wd;
        i_we[p]              = we;
        i_addr[p*32 +: 32]   = a;
        i_len[p*2 +: 2]      = len;
        i_wdata[p*32 +: 32]  = wd;
        i_req[p]             = 1'b1;
    endtask

    // Follows one burst of port p from its grant edge to its done cycle, checking every cycle.
    task automatic expect_burst(input int p, output logic [31:0] got_rd);
        int          n;
        int          done_at;
        logic [31:0] exp_rd;
        logic [31:0] ak;
        logic [31:0] t;
        logic [1:0]  oh;
        oh      = (p == 0) ? 2'b01 : 2'b10;
        n       = int'(b_len[p]) + 1;
        done_at = b_we[p] ? n : n + 1;
        exp_rd  = 32'h0;
        got_rd  = 32'h0;
        for (int k = 0; k < n; k++) begin
            ak = b_addr[p] + 32'(k);
            exp_rd = exp_rd | ({shadow[ak[7:0]], 24'h0} >> (8 * k));
        end
        @(posedge clk); #1;
        for (int c = 0; c <= done_at; c++) begin
            if (c < done_at) begin
                check("gnt", {30'b0, o_gnt}, {30'b0, oh});
                check("done_early", {30'b0, o_done}, 32'h0);
                if (c < n) begin
                    check("mem_addr", o_mem_addr, b_addr[p] + 32'(c));
                    check("mem_we", {31'b0, o_mem_we}, {31'b0, b_we[p]});
                    if (b_we[p]) begin
                        t = b_wdata[p] << (8 * c);
                        check("mem_wdata", {24'b0, o_mem_wdata}, {24'b0, t[31:24]});
                    end
                end else begin
                    check("mem_we_drain", {31'b0, o_mem_we}, 32'h0);
                end
                @(posedge clk); #1;
            end else begin
                check("done", {30'b0, o_done}, {30'b0, oh});
                check("gnt_at_done", {30'b0, o_gnt}, 32'h0);
                check("mem_we_at_done", {31'b0, o_mem_we}, 32'h0);
                if (!b_we[p]) check("rdata", o_rdata, exp_rd);
                got_rd   = o_rdata;
                i_req[p] = 1'b0;
            end
        end
        if (b_we[p]) begin
            for (int k = 0; k < n; k++) begin
                ak = b_addr[p] + 32'(k);
                t  = b_wdata[p] << (8 * k);
                shadow[ak[7:0]] = t[31:24];
            end
        end
        tb_last = p;
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        checks   = 0;
        errors   = 0;
        tb_last  = 1;
        i_req    = 2'b00;
        i_we     = 2'b00;
        i_addr   = 64'h0;
        i_len    = 4'h0;
        i_wdata  = 64'h0;
        for (int i = 0; i < 256; i++) shadow[i] = init_byte(i);

        vecs[0] = '{0, 1'b0, 32'h0000_0000, 2'd3, 32'h0,          32'hAABB_CCDD};
        vecs[1] = '{1, 1'b1, 32'h0000_0010, 2'd1, 32'h1234_5678,  32'h0};
        vecs[2] = '{0, 1'b0, 32'h0000_0002, 2'd1, 32'h0,          32'hCCDD_0000};
        vecs[3] = '{1, 1'b0, 32'h0000_0010, 2'd1, 32'h0,          32'h1234_0000};
        vecs[4] = '{0, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0,          32'h5AAA_0000};
        vecs[5] = '{0, 1'b0, 32'h0000_0001, 2'd0, 32'h0,          32'hBB00_0000};
        vecs[6] = '{1, 1'b1, 32'h0000_0020, 2'd2, 32'hCAFE_F00D,  32'h0};
        vecs[7] = '{0, 1'b0, 32'h0000_0020, 2'd3, 32'h0,          32'hCAFE_F000};

        rst      = 1'b1;
        load_mem = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {30'b0, o_gnt}, 32'h0);
        check("rst_done", {30'b0, o_done}, 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_mem_we", {31'b0, o_mem_we}, 32'h0);
        check("rst_mem_wdata", {24'b0, o_mem_wdata}, 32'h0);
        rst      = 1'b0;
        load_mem = 1'b0;

        // Contention straight after reset: fetch first, then LSU with no bubble, then fetch again.
        set_port(0, 1'b0, 32'h0, 2'd3, 32'h0);
        set_port(1, 1'b0, 32'h2, 2'd1, 32'h0);
        expect_burst(0, rd);
        expect_burst(1, rd);
        set_port(0, 1'b0, 32'h1, 2'd2, 32'h0);
        set_port(1, 1'b0, 32'h3, 2'd0, 32'h0);
        expect_burst(0, rd);
        expect_burst(1, rd);

        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            set_port(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].wdata);
            expect_burst(vecs[v].port, rd);
            if (!vecs[v].we) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
        end

        // Reset lands on E2 of a 4-byte read; the held request restarts from byte 0.
        @(posedge clk); #1;
        set_port(0, 1'b0, 32'h0, 2'd3, 32'h0);
        @(posedge clk); #1;
        check("pre_rst_gnt", {30'b0, o_gnt}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_gnt", {30'b0, o_gnt}, 32'h0);
        check("mid_rst_we", {31'b0, o_mem_we}, 32'h0);
        check("mid_rst_rdata", o_rdata, 32'h0);
        check("mid_rst_done", {30'b0, o_done}, 32'h0);
        rst     = 1'b0;
        tb_last = 1;
        expect_burst(0, rd);
        check("restart_rdata", rd, 32'hAABB_CCDD);

        for (int r = 0; r < 40; r++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 2) == 0) begin
                set_port(0, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
                set_port(1, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
                w = (tb_last == 1) ? 0 : 1;
                expect_burst(w, rd);
                expect_burst(1 - w, rd);
            end else begin
                w = int'($urandom_range(0, 1));
                set_port(w, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
                expect_burst(w, rd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
